// File: rtl/seq_detector_n.sv
// Serial pattern detector: shifts valid input bits into an N-bit history and
// emits a registered one-cycle pulse plus a saturating count on each match.
module seq_detector_n #(
  parameter int              N       = 4,
  parameter logic [N-1:0]    PATTERN = 4'b1011,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W    = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [N-1:0]      r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [N-1:0]      r_pat;
  logic              r_dout;
  logic [CNT_W-1:0]  r_cnt;

  logic [N-1:0]      w_histNext;
  logic [FILL_W-1:0] w_fillNext;
  logic              w_shift;
  logic              w_match;

  // pat_load wins over din_valid, so a bit presented with a load never shifts in
  assign w_shift    = din_valid && !pat_load;
  assign w_histNext = {r_hist[N-2:0], din};
  assign w_fillNext = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
  assign w_match    = w_shift && (w_fillNext == FILL_FULL) && (w_histNext == r_pat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= PATTERN;
      r_dout <= 1'b0;
    end else begin
      r_dout <= w_match;
      if (pat_load) begin
        r_pat  <= pat_in;
        r_hist <= '0;
        r_fill <= '0;
      end else if (din_valid) begin
        r_hist <= w_histNext;
        // Non-overlapping mode restarts the fill so the next match needs N fresh bits
        r_fill <= (w_match && !OVERLAP) ? '0 : w_fillNext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dout      = r_dout;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detector_n.sv
// Self-checking bench for seq_detector_n: three instances (overlap, non-overlap,
// narrow counter) share stimulus and are compared to a bit-log reference model.
module tb_seq_detector_n;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic din_valid;
  logic pat_load;
  logic [N-1:0] pat_in;
  logic cnt_clr;

  logic dout0, dout1, dout2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detector_n #(.N(N), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .dout(dout0), .match_cnt(cnt0));

  seq_detector_n #(.N(N), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .dout(dout1), .match_cnt(cnt1));

  seq_detector_n #(.N(N), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .dout(dout2), .match_cnt(cnt2));

  int checks = 0;
  int errors = 0;

  // Reference model: every accepted bit since the last reset/load is logged;
  // each instance remembers where its current detection window begins.
  int bitLog[$];
  int winStart[3];
  int modelPat;
  int modelCnt[3];
  int modelDout[3];
  int cntMax[3]  = '{255, 255, 3};
  int overlap[3] = '{1, 0, 1};

  task automatic modelReset();
    bitLog.delete();
    modelPat = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      winStart[k] = 0;
      modelCnt[k] = 0;
      modelDout[k] = 0;
    end
  endtask

  task automatic modelEdge(input int d, input int v, input int l, input int p, input int c);
    int matched[3];
    for (int k = 0; k < 3; k++) matched[k] = 0;
    if (l != 0) begin
      bitLog.delete();
      for (int k = 0; k < 3; k++) winStart[k] = 0;
      modelPat = p;
    end else if (v != 0) begin
      bitLog.push_back(d);
      for (int k = 0; k < 3; k++) begin
        if (bitLog.size() - winStart[k] >= N) begin
          int val = 0;
          for (int i = 0; i < N; i++) val = val * 2 + bitLog[bitLog.size() - N + i];
          if (val == modelPat) begin
            matched[k] = 1;
            if (overlap[k] == 0) winStart[k] = bitLog.size();
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      modelDout[k] = matched[k];
      if (c != 0) modelCnt[k] = matched[k];
      else if (matched[k] != 0 && modelCnt[k] < cntMax[k]) modelCnt[k]++;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkAllModel(input string tag);
    checkOutput({tag, " dout0"}, int'(dout0), modelDout[0]);
    checkOutput({tag, " dout1"}, int'(dout1), modelDout[1]);
    checkOutput({tag, " dout2"}, int'(dout2), modelDout[2]);
    checkOutput({tag, " cnt0"},  int'(cnt0),  modelCnt[0]);
    checkOutput({tag, " cnt1"},  int'(cnt1),  modelCnt[1]);
    checkOutput({tag, " cnt2"},  int'(cnt2),  modelCnt[2]);
  endtask

  // Drive between edges, let the rising edge sample, then settle 1 time unit.
  task automatic applyStimulus(input logic d, input logic v, input logic l,
                               input logic [N-1:0] p, input logic c);
    @(negedge clk);
    din = d; din_valid = v; pat_load = l; pat_in = p; cnt_clr = c;
    @(posedge clk);
    modelEdge(int'(d), int'(v), int'(l), int'(p), int'(c));
    #1;
  endtask

  typedef struct {
    logic din;
    logic valid;
    logic expD0;
    logic expD1;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int s035[16];
    int ones;

    rst = 1'b0; din = 1'b0; din_valid = 1'b0; pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    modelReset();
    #3;
    checkOutput("reset dout0", int'(dout0), 0);
    checkOutput("reset cnt0", int'(cnt0), 0);
    @(negedge clk);
    rst = 1'b1;

    // Stream 0,1,0,1,1,0,1,1,0,1,0 from reset
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].din, tbl[i].valid, 1'b0, 4'b0000, 1'b0);
      checkOutput($sformatf("tbl%0d dout0", i), int'(dout0), int'(tbl[i].expD0));
      checkOutput($sformatf("tbl%0d dout1", i), int'(dout1), int'(tbl[i].expD1));
      checkAllModel($sformatf("tbl%0d", i));
    end
    checkOutput("overlap count", int'(cnt0), 2);
    checkOutput("nonoverlap count", int'(cnt1), 1);

    // Gaps in din_valid must not break a partial match
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      checkOutput("gap no pulse", int'(dout0), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    checkOutput("gap final pulse", int'(dout0), 1);
    checkOutput("gap final cnt", int'(cnt0), 1);
    checkAllModel("gap");

    // Runtime pattern load with a concurrent valid bit that must be discarded
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    checkOutput("load dout", int'(dout0), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    checkOutput("load early", int'(dout0), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    checkOutput("load pulse", int'(dout0), 1);
    checkAllModel("load");

    // All-ones pattern: overlap pulses every valid bit after the first N
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      checkOutput($sformatf("ones%0d dout0", i), int'(dout0), (i >= 3) ? 1 : 0);
      checkOutput($sformatf("ones%0d dout1", i), int'(dout1), (i == 3) ? 1 : 0);
    end
    checkAllModel("ones");

    // Narrow counter saturation, then clear coincident with a match
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    checkOutput("clr cnt2", int'(cnt2), 0);
    s035 = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(s035[i][0], 1'b1, 1'b0, 4'b0000, 1'b0);
      if (i % 3 == 0 && i > 0) begin
        ones++;
        checkOutput($sformatf("sat match%0d", ones), int'(cnt2), (ones > 3) ? 3 : ones);
      end
    end
    checkAllModel("sat");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    checkOutput("clr+match cnt2", int'(cnt2), 1);
    checkOutput("clr+match cnt0", int'(cnt0), 1);
    checkAllModel("clrmatch");

    // Asynchronous reset between edges, mid-pattern
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    #1;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("async rst cnt0", int'(cnt0), 0);
    checkOutput("async rst cnt2", int'(cnt2), 0);
    checkAllModel("async");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    checkOutput("post rst no pulse", int'(dout0), 0);
    checkAllModel("postrst");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 49) == 0),
                    4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 39) == 0));
      checkAllModel($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_n.md
SEQ_DETECTOR_N -- requirements
Module: seq_detector_n

Interface
REQ-001 Parameter N, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: N-bit reset-time pattern, MSB is the oldest bit.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 din  input  1  serial data bit.
REQ-008 din_valid  input  1  din is sampled only when high.
REQ-009 pat_load  input  1  loads pat_in as the active pattern.
REQ-010 pat_in  input  N  runtime pattern value, MSB oldest.
REQ-011 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 dout  output  1  registered one-cycle match pulse.
REQ-013 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-014 The block SHALL hold an N-bit history register hist, a fill counter fill (0..N), and an active pattern register pat.
REQ-015 On an edge with din_valid=1 and pat_load=0, the block SHALL set hist to {hist[N-2:0], din} and fill to min(fill+1, N).
REQ-016 A match SHALL occur on that edge when the updated fill equals N and the updated hist equals pat.
REQ-017 dout SHALL be 1 for exactly the one cycle following the edge at which a match occurs, and 0 otherwise.
REQ-018 Latency SHALL be 1 clock: dout rises at the same edge that samples the completing bit.
REQ-019 With OVERLAP=1, after a match fill SHALL stay at N so that suffix bits count toward the next match (stream 1011011 yields 2 matches).
REQ-020 With OVERLAP=0, a match SHALL set fill to 0 so the next match needs N fresh valid bits (stream 1011011 yields 1 match).
REQ-021 On edges with din_valid=0, hist, fill and pat SHALL hold and dout SHALL be 0; gaps do not break a partial match.
REQ-022 pat_load=1 at an edge SHALL set pat to pat_in, hist to 0 and fill to 0, and dout SHALL be 0 next cycle.
REQ-023 pat_load SHALL take precedence over din_valid in the same cycle; that din bit SHALL be discarded.
REQ-024 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-025 If cnt_clr and a match occur at the same edge, match_cnt SHALL become 1.
REQ-026 If cnt_clr occurs without a match, match_cnt SHALL become 0.
REQ-027 A pattern of all zeros or all ones SHALL be legal; in overlap mode a constant stream SHALL then pulse dout every valid cycle after the first N bits.

Reset
REQ-028 While rst=0, the block SHALL asynchronously force hist=0, fill=0, pat=PATTERN, dout=0 and match_cnt=0, independent of clk.
REQ-029 Reset asserted mid-pattern SHALL discard all partial history; after release, detection SHALL need N new valid bits.
REQ-030 The first edge after rst deasserts SHALL be a normal functional edge.

Verification
REQ-031 Defaults, OVERLAP=1, din_valid=1, stream 0,1,0,1,1,0,1,1,0,1,0 -> dout pulses after bits 4 and 7 (0-indexed); match_cnt=2.
REQ-032 Same stream with OVERLAP=0 -> single dout pulse after bit 4; match_cnt=1.
REQ-033 Stream 1,0,1 with din_valid=0 for 3 cycles, then 1 -> exactly one pulse after the final 1.
REQ-034 pat_load with pat_in=4'b0110 concurrent with a valid din, then stream 0,1,1,0 -> one pulse; the bit presented with pat_load is ignored.
REQ-035 CNT_W=2, 5 matches -> match_cnt reads 1, 2, 3, 3, 3; cnt_clr coincident with a match -> 1.
REQ-036 rst=0 asserted between clock edges after bits 1,0,1 -> dout and match_cnt go to 0 immediately; after release, a single 1 produces no pulse.
